// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM state
// encoding and the legality/misalignment checks used when an access starts.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // funct3 codes 011/110/111 have no RV32I load/store meaning.
  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: is_misaligned = addr_lo[0];
      F3_W:        is_misaligned = (addr_lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: one request held until mem_ready.
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data/strobe steering and load
// extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store steering keyed on the access size (funct3[1:0]).
  always_comb begin
    mem_wdata_o = wdata_i;
    wstrb_o     = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        mem_wdata_o = {4{wdata_i[7:0]}};
        wstrb_o     = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        mem_wdata_o = {2{wdata_i[15:0]}};
        if (addr_lo_i[1]) begin
          wstrb_o = 4'b1100;
        end else begin
          wstrb_o = 4'b0011;
        end
      end
      default: begin
        mem_wdata_o = wdata_i;
        wstrb_o     = 4'b1111;
      end
    endcase
  end

  // Lane selection for sub-word loads.
  always_comb begin
    byte_s = mem_rdata_i[7:0];
    case (addr_lo_i)
      2'b00:   byte_s = mem_rdata_i[7:0];
      2'b01:   byte_s = mem_rdata_i[15:8];
      2'b10:   byte_s = mem_rdata_i[23:16];
      2'b11:   byte_s = mem_rdata_i[31:24];
      default: byte_s = mem_rdata_i[7:0];
    endcase
    if (addr_lo_i[1]) begin
      half_s = mem_rdata_i[31:16];
    end else begin
      half_s = mem_rdata_i[15:0];
    end
  end

  // Extension to the 32-bit writeback value.
  always_comb begin
    load_data_o = mem_rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data_o = {24'h000000, byte_s};
      F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data_o = {16'h0000, half_s};
      default: load_data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: IDLE/REQ/DONE FSM with a wait-state
// timeout, stalling the core while a memory access is in flight.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               stall,
  output logic               done,
  output logic               err,
  load_store_unit_if.master  mem
);

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [31:0] wdata_q, wdata_d;
  logic        abort_q, abort_d;
  logic [31:0] rdata_q, rdata_d;

  logic        in_idle_s;
  logic        in_req_s;
  logic        start_bad_s;
  logic        legal_start_s;
  logic        illegal_start_s;
  logic [31:0] steer_wdata_s;
  logic [3:0]  steer_wstrb_s;
  logic [31:0] load_data_s;

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem.mem_rdata),
    .mem_wdata_o (steer_wdata_s),
    .wstrb_o     (steer_wstrb_s),
    .load_data_o (load_data_s)
  );

  // Start qualification is masked during reset so every output reads 0.
  assign in_idle_s       = (state_q == ST_IDLE);
  assign in_req_s        = (state_q == ST_REQ);
  assign start_bad_s     = !f3_legal(funct3) || is_misaligned(funct3, addr[1:0]);
  assign legal_start_s   = in_idle_s && start && !rst && !start_bad_s;
  assign illegal_start_s = in_idle_s && start && !rst && start_bad_s;

  // State and latched access registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 32'h0000_0000;
      funct3_q   <= 3'b000;
      is_store_q <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      abort_q    <= 1'b0;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      wdata_q    <= wdata_d;
      abort_q    <= abort_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic; mem_ready wins over the timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    wdata_d    = wdata_q;
    abort_d    = abort_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (legal_start_s) begin
          addr_d     = addr;
          funct3_d   = funct3;
          is_store_d = is_store;
          wdata_d    = wdata;
          cnt_d      = 8'd0;
          abort_d    = 1'b0;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem.mem_ready) begin
          state_d = ST_DONE;
          if (!is_store_q) begin
            rdata_d = load_data_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if ((cnt_q + 8'd1) == TIMEOUT_L) begin
          cnt_d   = cnt_q + 8'd1;
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rdata = rdata_q;
  assign stall = legal_start_s || in_req_s;
  assign done  = (state_q == ST_DONE);
  assign err   = illegal_start_s || ((state_q == ST_DONE) && abort_q);

  // The bus is quiet outside REQ; loads never assert write strobes.
  assign mem.mem_req   = in_req_s;
  assign mem.mem_we    = in_req_s && is_store_q;
  assign mem.mem_addr  = in_req_s ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
  assign mem.mem_wstrb = (in_req_s && is_store_q) ? steer_wstrb_s : 4'b0000;
  assign mem.mem_wdata = (in_req_s && is_store_q) ? steer_wdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues the expected retire
// response, a negedge monitor pops and compares on every done/err pulse.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;

  load_store_unit_if mem_if();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .err      (err),
    .mem      (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        resp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 32'h0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_response", {30'h0, done, err}, 32'h0);
      end else begin
        mon_e = resp_q.pop_front();
        chk("resp_done", {31'h0, done}, {31'h0, mon_e.done});
        chk("resp_err", {31'h0, err}, {31'h0, mon_e.err});
        if (mon_e.chk_rd) chk("resp_rdata", rdata, mon_e.rdata);
      end
    end
  end

  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int waits, input logic [31:0] mrd,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd, input bit exp_to,
                            input logic [31:0] exp_rd, input bit hold_start);
    exp_t e;
    e.done = 1'b1; e.err = exp_to; e.chk_rd = 1'b1; e.rdata = exp_rd;
    resp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    chk("stall_c0", {31'h0, stall}, 32'h1);
    chk("req_c0", {31'h0, mem_if.mem_req}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i <= waits; i++) begin
      mem_if.mem_ready = (i == waits) && !exp_to;
      mem_if.mem_rdata = (i == waits) ? mrd : 32'hA5A5_A5A5;
      @(negedge clk);
      chk("req_held", {31'h0, mem_if.mem_req}, 32'h1);
      chk("stall_req", {31'h0, stall}, 32'h1);
      chk("mem_addr", mem_if.mem_addr, exp_addr);
      chk("mem_we", {31'h0, mem_if.mem_we}, {31'h0, st});
      chk("mem_wstrb", {28'h0, mem_if.mem_wstrb}, {28'h0, exp_strb});
      if (st) chk("mem_wdata", mem_if.mem_wdata, exp_wd);
      @(posedge clk); #1;
    end
    mem_if.mem_ready = 1'b0;
    if (hold_start) begin
      start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h0000_0500;
    end
    @(negedge clk);
    chk("stall_done", {31'h0, stall}, 32'h0);
    if (hold_start) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", {31'h0, mem_if.mem_req}, 32'h0);
    end
    last_rd = exp_rd;
  endtask

  task automatic run_illegal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    exp_t e;
    e.done = 1'b0; e.err = 1'b1; e.chk_rd = 1'b1; e.rdata = last_rd;
    resp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("illegal_stall", {31'h0, stall}, 32'h0);
    chk("illegal_req", {31'h0, mem_if.mem_req}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("illegal_req_after", {31'h0, mem_if.mem_req}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {28'h0, stall, done, err, mem_if.mem_req}, 32'h0);
    chk("rst_bus", {27'h0, mem_if.mem_we, mem_if.mem_wstrb}, 32'h0);
    chk("rst_addr", mem_if.mem_addr, 32'h0);
    chk("rst_wdata", mem_if.mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    //         st  f3     addr          wdata         w  mrd           exp_addr      strb     exp_wd        to  exp_rd        hold
    run_access(0, F3_W,  32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0,        0, 32'hDEAD_BEEF, 0);
    run_access(0, F3_B,  32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 32'h0000_0100, 4'b0000, 32'h0,        0, 32'hFFFF_FF80, 0);
    run_access(0, F3_BU, 32'h0000_0103, 32'h0,        0, 32'h80FF_0000, 32'h0000_0100, 4'b0000, 32'h0,        0, 32'h0000_0080, 0);
    run_access(1, F3_H,  32'h0000_0202, 32'h1234_ABCD, 3, 32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 0, 32'h0000_0080, 0);
    run_access(1, F3_B,  32'h0000_0101, 32'h1122_3344, 0, 32'h0,        32'h0000_0100, 4'b0010, 32'h4444_4444, 0, 32'h0000_0080, 0);
    run_access(1, F3_W,  32'h0000_0204, 32'hCAFE_F00D, 1, 32'h0,        32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 0, 32'h0000_0080, 0);
    run_access(0, F3_H,  32'h0000_0102, 32'h0,        1, 32'h8001_7FFF, 32'h0000_0100, 4'b0000, 32'h0,        0, 32'hFFFF_8001, 0);
    run_access(0, F3_HU, 32'h0000_0100, 32'h0,        2, 32'h8001_7FFF, 32'h0000_0100, 4'b0000, 32'h0,        0, 32'h0000_7FFF, 0);

    run_illegal(0, F3_W, 32'h0000_0101);
    run_illegal(0, 3'b011, 32'h0000_0100);
    run_illegal(1, F3_H, 32'h0000_0201);

    // Timeout: TO REQ cycles with mem_ready low, then done+err, rdata held.
    run_access(0, F3_W, 32'h0000_0400, 32'h0, TO - 1, 32'h0, 32'h0000_0400, 4'b0000, 32'h0, 1, 32'h0000_7FFF, 1);

    // Reset during the second REQ cycle of a load.
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h0000_0300;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_req1", {31'h0, mem_if.mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_req2", {31'h0, mem_if.mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags", {28'h0, stall, done, err, mem_if.mem_req}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    last_rd = 32'h0;
    run_access(0, F3_W, 32'h0000_0104, 32'h0, 0, 32'h0123_4567, 32'h0000_0104, 4'b0000, 32'h0, 0, 32'h0123_4567, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pending_responses", resp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
